// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM bus responder with wait states and byte-lane writes.
// Optional DMEM_ERR_EN: report range/alignment/mask errors on o_err.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  output logic        o_busy,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          drop;
  logic          err_flag;

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      bmask_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          bmask_d = i_bmask;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses below the base wrap to huge offsets, so one compare covers both ends.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = offset < WIN_BYTES;
  assign idx      = offset[AW+1:2];

`ifdef DMEM_ERR_EN
  logic shape_ok;
  logic misaligned;

  always_comb begin
    shape_ok   = 1'b1;
    misaligned = 1'b0;
    case (bmask_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: misaligned = 1'b0;
      4'b0011, 4'b0110, 4'b1100:          misaligned = addr_q[0];
      4'b1111:                            misaligned = |addr_q[1:0];
      default:                            shape_ok   = 1'b0;
    endcase
  end

  assign drop     = !in_range || !shape_ok || misaligned;
  assign err_flag = drop;
`else
  assign drop     = !in_range;
  assign err_flag = 1'b0;
`endif

  assign o_busy  = (state_q != ST_IDLE);
  assign o_ack   = (state_q == ST_RESP);
  assign o_err   = o_ack && err_flag;
  assign o_rdata = (o_ack && !we_q && !drop) ? mem[idx] : 32'd0;

  // Commit happens on the edge that ends RESP; a reset on that edge cancels it.
  always_ff @(posedge i_clk) begin
    if (rst && state_q == ST_RESP && we_q && !drop) begin
      for (int k = 0; k < 4; k++) begin
        if (bmask_q[k]) mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule
